// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - DIV/DIVU request and response bundle between EX and the divide sequencer
interface div_seq_if #(
  parameter int DATA_W = 32
);
  logic                  start;
  logic                  signed_div;
  logic [DATA_W-1:0]     opdata1;
  logic [DATA_W-1:0]     opdata2;
  logic                  annul;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;
  logic                  stall_req;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, stall_req
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, stall_req
  );
endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle restoring divider for DIV/DIVU producing {HI,LO}
// Optional DIV_EARLY_TERM_EN finishes in one edge when |dividend| < |divisor|.
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   div_io
);

  localparam int WORK_W = 2*DATA_W + 1;

  typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORK_W-1:0]     work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  quo_neg_q, quo_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic                  op1_neg, op2_neg;
  logic [DATA_W-1:0]     op1_abs, op2_abs;
  logic                  div_by_zero, early_done, iter_done;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     quo_raw, rem_raw, quo_fix, rem_fix;

  assign op1_neg     = div_io.signed_div & div_io.opdata1[DATA_W-1];
  assign op2_neg     = div_io.signed_div & div_io.opdata2[DATA_W-1];
  assign op1_abs     = op1_neg ? (~div_io.opdata1 + 1'b1) : div_io.opdata1;
  assign op2_abs     = op2_neg ? (~div_io.opdata2 + 1'b1) : div_io.opdata2;
  assign div_by_zero = (div_io.opdata2 == '0);

`ifdef DIV_EARLY_TERM_EN
  assign early_done = (op1_abs < op2_abs);
`else
  assign early_done = 1'b0;
`endif

  // Partial remainder is the top DATA_W+1 bits; a set MSB of diff means it was smaller than the divisor.
  assign diff      = work_q[WORK_W-1:DATA_W] - {1'b0, divisor_q};
  assign iter_done = (cnt_q == CNT_W'(DATA_W));
  assign quo_raw   = work_q[DATA_W-1:0];
  assign rem_raw   = work_q[WORK_W-1:DATA_W+1];
  assign quo_fix   = quo_neg_q ? (~quo_raw + 1'b1) : quo_raw;
  assign rem_fix   = rem_neg_q ? (~rem_raw + 1'b1) : rem_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (div_io.annul)      state_d = IDLE;
        else if (div_io.start) begin
          if (div_by_zero)     state_d = BYZERO;
          else if (early_done) state_d = DONE;
          else                 state_d = RUN;
        end
      end
      BYZERO:  state_d = div_io.annul ? IDLE : DONE;
      RUN: begin
        if (div_io.annul)      state_d = IDLE;
        else if (iter_done)    state_d = DONE;
      end
      DONE: begin
        if (!div_io.start || div_io.annul) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;
    unique case (state_q)
      IDLE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (!div_io.annul && div_io.start && !div_by_zero) begin
          work_d    = {{DATA_W{1'b0}}, op1_abs, 1'b0};
          divisor_d = op2_abs;
          cnt_d     = '0;
          quo_neg_d = op1_neg ^ op2_neg;
          rem_neg_d = op1_neg;
          if (early_done) begin
            result_d = {div_io.opdata1, {DATA_W{1'b0}}};
            ready_d  = 1'b1;
          end
        end
      end
      BYZERO: begin
        result_d = '0;
        ready_d  = !div_io.annul;
      end
      RUN: begin
        if (div_io.annul) begin
          result_d = '0;
          ready_d  = 1'b0;
        end else if (!iter_done) begin
          if (diff[DATA_W]) work_d = {work_q[WORK_W-2:0], 1'b0};
          else              work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          cnt_d = cnt_q + 1'b1;
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end
      DONE: begin
        if (!div_io.start || div_io.annul) begin
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    div_io.stall_req = div_io.start & (state_q != DONE);
    div_io.result    = result_q;
    div_io.ready     = ready_q;
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - vector table, corner sequences and randomized checks for div_seq
module tb_div_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_seq_if #(.DATA_W(32)) dif ();

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_io (dif)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mag(input bit sd, input logic [31:0] x);
    logic [31:0] n;
    n = ~x + 32'd1;
    return (sd && x[31]) ? n : x;
  endfunction

  // Reference: plain arithmetic, truncating signed division, INT_MIN/-1 wraps.
  function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (!sd) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  function automatic int ref_lat(input bit sd, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_TERM_EN
    if (mag(sd, a) < mag(sd, b)) return 1;
`else
    if (mag(sd, a) == 32'hFFFF_FFFF && sd) return 34;
`endif
    return 34;
  endfunction

  task automatic run_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit scramble, input string tag);
    int n, stalls, lat;
    bit seen;
    lat = ref_lat(sd, a, b);
    @(negedge clk);
    dif.start      = 1'b1;
    dif.signed_div = sd;
    dif.opdata1    = a;
    dif.opdata2    = b;
    dif.annul      = 1'b0;
    #1;
    stalls = dif.stall_req ? 1 : 0;
    n      = 0;
    seen   = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk);
      n++;
      #1;
      if (dif.ready) seen = 1'b1;
      else begin
        if (dif.stall_req) stalls++;
        if (scramble && n > 2) begin
          dif.opdata1    = $urandom;
          dif.opdata2    = $urandom;
          dif.signed_div = 1'($urandom_range(0, 1));
        end
      end
    end
    chk({tag, " ready"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " stall_cycles"}, 64'(stalls), 64'(lat));
    chk({tag, " result"}, dif.result, exp);
    chk({tag, " stall_done"}, 64'(dif.stall_req), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, " hold_ready"}, 64'(dif.ready), 64'd1);
    chk({tag, " hold_result"}, dif.result, exp);
    @(negedge clk);
    dif.start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " drop_ready"}, 64'(dif.ready), 64'd0);
    chk({tag, " drop_result"}, dif.result, 64'd0);
  endtask

  initial begin
    bit          saw_ready;
    bit          sd;
    logic [31:0] a, b;

    tbl[0]  = '{1'b0, 32'd7,          32'd2,          64'h00000001_00000003};
    tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD};
    tbl[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD};
    tbl[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000};
    tbl[4]  = '{1'b0, 32'd5,          32'd0,          64'h00000000_00000000};
    tbl[5]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
    tbl[6]  = '{1'b0, 32'd3,          32'd10,         64'h00000003_00000000};
    tbl[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF};
    tbl[8]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000000_00000001};
    tbl[9]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  64'hFFFFFFFF_00000003};
    tbl[10] = '{1'b0, 32'h8000_0001,  32'h8000_0000,  64'h00000001_00000001};
    tbl[11] = '{1'b1, 32'hFFFF_FFFD,  32'd10,         64'hFFFFFFFD_00000000};

    rst            = 1'b1;
    dif.start      = 1'b0;
    dif.signed_div = 1'b0;
    dif.opdata1    = '0;
    dif.opdata2    = '0;
    dif.annul      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset ready", 64'(dif.ready), 64'd0);
    chk("reset result", dif.result, 64'd0);
    chk("reset stall", 64'(dif.stall_req), 64'd0);

    for (int i = 0; i < 12; i++)
      run_div(tbl[i].sd, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0, $sformatf("tbl%0d", i));

    // Annul at cnt=10 must abort without ever raising ready.
    saw_ready = 1'b0;
    @(negedge clk);
    dif.start = 1'b1; dif.signed_div = 1'b0; dif.opdata1 = 32'd100; dif.opdata2 = 32'd7;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      if (dif.ready) saw_ready = 1'b1;
    end
    @(negedge clk);
    dif.annul = 1'b1;
    @(posedge clk);
    #1;
    chk("annul ready", 64'(dif.ready), 64'd0);
    chk("annul result", dif.result, 64'd0);
    chk("annul stall", 64'(dif.stall_req), 64'd1);
    @(negedge clk);
    dif.annul = 1'b0;
    dif.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (dif.ready) saw_ready = 1'b1;
    end
    chk("annul never_ready", 64'(saw_ready), 64'd0);
    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, "after_annul");

    // Annul beats start in IDLE: the divide must start only once annul drops.
    @(negedge clk);
    dif.start = 1'b1; dif.annul = 1'b1; dif.signed_div = 1'b0;
    dif.opdata1 = 32'd7; dif.opdata2 = 32'd2;
    @(posedge clk);
    #1;
    chk("annul_idle ready", 64'(dif.ready), 64'd0);
    run_div(1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 1'b0, "annul_idle");

    // Synchronous reset in the middle of RUN.
    @(negedge clk);
    dif.start = 1'b1; dif.opdata1 = 32'd1000; dif.opdata2 = 32'd3;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    dif.start = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst ready", 64'(dif.ready), 64'd0);
    chk("midrst result", dif.result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_div(1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 1'b1, "after_rst");

    for (int i = 0; i < 150; i++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        4: a = $urandom_range(0, 20);
        5: b = {1'b1, b[30:0]};
        default: ;
      endcase
      run_div(sd, a, b, ref_div(sd, a, b), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
